// File: rtl/hundredths_stopwatch.sv
// BCD mm:ss.hh stopwatch driven by the hundredths divider, with start/stop/clear control.
// Lap capture with a valid/ready output is built only when STOPWATCH_LAP_EN is defined.
module hundredths_stopwatch #(
    parameter int MINUTE_LIMIT = 60
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clock_divide,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_clear,
    input  logic        i_lap,
    input  logic        i_lap_ready,
    output logic        o_running,
    output logic [23:0] o_time_bcd,
    output logic [23:0] o_lap_bcd,
    output logic        o_lap_valid,
    output logic        o_overflow
);

    localparam logic [3:0] MIN_TENS_MAX = 4'((MINUTE_LIMIT - 1) / 10);
    localparam logic [3:0] MIN_ONES_MAX = 4'((MINUTE_LIMIT - 1) % 10);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_prev_div;
    logic       w_tick;
    logic       w_count;
    logic       w_wrap;
    logic       r_overflow;
    logic [3:0] r_min_t, r_min_o, r_sec_t, r_sec_o, r_hun_t, r_hun_o;
    logic [3:0] w_min_t, w_min_o, w_sec_t, w_sec_o, w_hun_t, w_hun_o;

    assign w_tick     = i_clock_divide & ~r_prev_div;
    assign o_time_bcd = {r_min_t, r_min_o, r_sec_t, r_sec_o, r_hun_t, r_hun_o};
    assign o_running  = (r_state == RUN);
    assign o_overflow = r_overflow;

    // A stop or clear in the same cycle as a tick suppresses that tick.
    assign w_count = (r_state == RUN) & w_tick & ~i_clear & ~i_stop;

    always_comb begin
        w_next_state = r_state;
        if (i_clear) begin
            w_next_state = IDLE;
        end else if (i_stop) begin
            if (r_state == RUN) begin
                w_next_state = PAUSE;
            end
        end else if (i_start) begin
            if (r_state != RUN) begin
                w_next_state = RUN;
            end
        end
    end

    always_comb begin
        w_min_t = r_min_t;
        w_min_o = r_min_o;
        w_sec_t = r_sec_t;
        w_sec_o = r_sec_o;
        w_hun_t = r_hun_t;
        w_hun_o = r_hun_o;
        w_wrap  = 1'b0;
        if (w_count) begin
            if (r_hun_o != 4'd9) begin
                w_hun_o = r_hun_o + 4'd1;
            end else begin
                w_hun_o = 4'd0;
                if (r_hun_t != 4'd9) begin
                    w_hun_t = r_hun_t + 4'd1;
                end else begin
                    w_hun_t = 4'd0;
                    if (r_sec_o != 4'd9) begin
                        w_sec_o = r_sec_o + 4'd1;
                    end else begin
                        w_sec_o = 4'd0;
                        if (r_sec_t != 4'd5) begin
                            w_sec_t = r_sec_t + 4'd1;
                        end else begin
                            w_sec_t = 4'd0;
                            // Wrap is detected on the full minute value so odd limits like 45 work.
                            if (r_min_t == MIN_TENS_MAX && r_min_o == MIN_ONES_MAX) begin
                                w_min_t = 4'd0;
                                w_min_o = 4'd0;
                                w_wrap  = 1'b1;
                            end else if (r_min_o != 4'd9) begin
                                w_min_o = r_min_o + 4'd1;
                            end else begin
                                w_min_o = 4'd0;
                                w_min_t = r_min_t + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_prev_div <= 1'b0;
            r_overflow <= 1'b0;
            r_min_t    <= 4'd0;
            r_min_o    <= 4'd0;
            r_sec_t    <= 4'd0;
            r_sec_o    <= 4'd0;
            r_hun_t    <= 4'd0;
            r_hun_o    <= 4'd0;
        end else begin
            r_state    <= w_next_state;
            r_prev_div <= i_clock_divide;
            if (i_clear) begin
                r_overflow <= 1'b0;
                r_min_t    <= 4'd0;
                r_min_o    <= 4'd0;
                r_sec_t    <= 4'd0;
                r_sec_o    <= 4'd0;
                r_hun_t    <= 4'd0;
                r_hun_o    <= 4'd0;
            end else begin
                if (w_wrap) begin
                    r_overflow <= 1'b1;
                end
                r_min_t <= w_min_t;
                r_min_o <= w_min_o;
                r_sec_t <= w_sec_t;
                r_sec_o <= w_sec_o;
                r_hun_t <= w_hun_t;
                r_hun_o <= w_hun_o;
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [23:0] r_lap_bcd;
    logic        r_lap_valid;
    logic        w_lap_load;

    // A lap loads only when the output slot is free or being consumed this cycle.
    assign w_lap_load  = i_lap & (r_state != IDLE) & (~r_lap_valid | i_lap_ready);
    assign o_lap_bcd   = r_lap_bcd;
    assign o_lap_valid = r_lap_valid;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_lap_bcd   <= 24'd0;
            r_lap_valid <= 1'b0;
        end else if (i_clear) begin
            r_lap_valid <= 1'b0;
        end else if (w_lap_load) begin
            r_lap_bcd   <= o_time_bcd;
            r_lap_valid <= 1'b1;
        end else if (r_lap_valid && i_lap_ready) begin
            r_lap_valid <= 1'b0;
        end
    end
`else
    logic w_lap_unused;

    assign w_lap_unused = i_lap ^ i_lap_ready;
    assign o_lap_bcd    = 24'd0;
    assign o_lap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_hundredths_stopwatch.sv
// Self-checking bench for hundredths_stopwatch: a 60-minute and a 1-minute instance share stimulus
// and are compared every cycle against an integer-hundredths model, plus literal spot checks.
module tb_hundredths_stopwatch;

    logic clk;
    logic resetN;
    logic clockDivide;
    logic start;
    logic stop;
    logic clear;
    logic lap;
    logic lapReady;

    logic        runA, runB;
    logic [23:0] timeA, timeB;
    logic [23:0] lapA, lapB;
    logic        lapValidA, lapValidB;
    logic        ovfA, ovfB;

    int nChecks = 0;
    int nErrors = 0;

    hundredths_stopwatch #(.MINUTE_LIMIT(60)) dutA (
        .i_clk(clk), .i_reset_n(resetN), .i_clock_divide(clockDivide),
        .i_start(start), .i_stop(stop), .i_clear(clear),
        .i_lap(lap), .i_lap_ready(lapReady),
        .o_running(runA), .o_time_bcd(timeA), .o_lap_bcd(lapA),
        .o_lap_valid(lapValidA), .o_overflow(ovfA)
    );

    hundredths_stopwatch #(.MINUTE_LIMIT(1)) dutB (
        .i_clk(clk), .i_reset_n(resetN), .i_clock_divide(clockDivide),
        .i_start(start), .i_stop(stop), .i_clear(clear),
        .i_lap(lap), .i_lap_ready(lapReady),
        .o_running(runB), .o_time_bcd(timeB), .o_lap_bcd(lapB),
        .o_lap_valid(lapValidB), .o_overflow(ovfB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    // Model: elapsed time is a plain count of hundredths; modes 0=idle 1=run 2=pause.
    int          modelLimit [2] = '{60, 1};
    int          modelHund  [2];
    int          modelMode  [2];
    bit          modelOvf   [2];
    bit          modelLv    [2];
    logic [23:0] modelLb    [2];
    bit          modelPrev;
    bit          modelLive = 1'b0;

    function automatic logic [23:0] toBcd(input int h);
        int hun = h % 100;
        int sec = (h / 100) % 60;
        int mn  = h / 6000;
        return {4'(mn / 10), 4'(mn % 10), 4'(sec / 10), 4'(sec % 10), 4'(hun / 10), 4'(hun % 10)};
    endfunction

    task automatic modelStep(input int k, input bit tick);
        logic [23:0] nowBcd;
        bit doCount;
        nowBcd  = toBcd(modelHund[k]);
        doCount = 1'b0;
        if (clear) begin
            modelMode[k] = 0;
            modelHund[k] = 0;
            modelOvf[k]  = 1'b0;
            modelLv[k]   = 1'b0;
        end else begin
            if (LAP_EN) begin
                if (lap && modelMode[k] != 0 && (!modelLv[k] || lapReady)) begin
                    modelLb[k] = nowBcd;
                    modelLv[k] = 1'b1;
                end else if (modelLv[k] && lapReady) begin
                    modelLv[k] = 1'b0;
                end
            end
            if (stop) begin
                if (modelMode[k] == 1) modelMode[k] = 2;
            end else if (start && modelMode[k] != 1) begin
                modelMode[k] = 1;
            end else begin
                doCount = (modelMode[k] == 1) && tick;
            end
            if (doCount) begin
                modelHund[k] = modelHund[k] + 1;
                if (modelHund[k] == modelLimit[k] * 6000) begin
                    modelHund[k] = 0;
                    modelOvf[k]  = 1'b1;
                end
            end
        end
    endtask

    // Model advances on each rising edge from the same inputs the DUTs sample.
    always @(posedge clk) begin
        bit tick;
        if (!resetN) begin
            for (int k = 0; k < 2; k++) begin
                modelHund[k] = 0;
                modelMode[k] = 0;
                modelOvf[k]  = 1'b0;
                modelLv[k]   = 1'b0;
                modelLb[k]   = 24'd0;
            end
            modelPrev = 1'b0;
            modelLive = 1'b1;
        end else begin
            tick      = clockDivide && !modelPrev;
            modelPrev = clockDivide;
            for (int k = 0; k < 2; k++) modelStep(k, tick);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model, 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (modelLive) begin
            checkOutput("cycleA", 64'({runA, ovfA, lapValidA, timeA, lapA}),
                        64'({modelMode[0] == 1, modelOvf[0], modelLv[0], toBcd(modelHund[0]), modelLb[0]}));
            checkOutput("cycleB", 64'({runB, ovfB, lapValidB, timeB, lapB}),
                        64'({modelMode[1] == 1, modelOvf[1], modelLv[1], toBcd(modelHund[1]), modelLb[1]}));
        end
    end

    // Called at a falling edge; drives one cycle of inputs, then drops the single-cycle commands.
    task automatic applyStimulus(input logic st, input logic sp, input logic cl,
                                 input logic lp, input logic rdy, input logic cdv);
        start       = st;
        stop        = sp;
        clear       = cl;
        lap         = lp;
        lapReady    = rdy;
        clockDivide = cdv;
        @(negedge clk);
        start    = 1'b0;
        stop     = 1'b0;
        clear    = 1'b0;
        lap      = 1'b0;
        lapReady = 1'b0;
    endtask

    task automatic tickN(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1);
            applyStimulus(0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetN      = 1'b0;
        clockDivide = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        clear       = 1'b0;
        lap         = 1'b0;
        lapReady    = 1'b0;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        checkOutput("resetState", 64'({runA, ovfA, lapValidA, timeA, lapA}), 64'd0);

        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("runningAfterStart", 64'(runA), 64'd1);
        tickN(150);
        checkOutput("time150", 64'(timeA), 64'h000150);
        checkOutput("overflow150", 64'(ovfA), 64'd0);

        for (int i = 0; i < 50; i++) applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("heldHighOneTick", 64'(timeA), 64'h000151);

        tickN(156);
        checkOutput("time307", 64'(timeA), 64'h000307);
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("clearStartTime", 64'(timeA), 64'h000000);
        checkOutput("clearStartIdle", 64'(runA), 64'd0);

        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("stopToPause", 64'(runA), 64'd0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("startStopStaysPause", 64'(runA), 64'd0);

        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("tickWithStartIgnored", 64'(timeA), 64'h000000);
        checkOutput("resumeRunning", 64'(runA), 64'd1);

        tickN(42);
        applyStimulus(0, 0, 0, 1, 0, 0);
`ifdef STOPWATCH_LAP_EN
        checkOutput("lapValid42", 64'(lapValidA), 64'd1);
        checkOutput("lapBcd42", 64'(lapA), 64'h000042);
`else
        checkOutput("lapValidTiedOff", 64'(lapValidA), 64'd0);
`endif
        tickN(8);
        applyStimulus(0, 0, 0, 1, 0, 0);
`ifdef STOPWATCH_LAP_EN
        checkOutput("lapDroppedWhilePending", 64'(lapA), 64'h000042);
`endif
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("lapConsumed", 64'(lapValidA), 64'd0);

        tickN(5);
        applyStimulus(0, 0, 0, 1, 0, 0);
        tickN(5);
        applyStimulus(0, 0, 0, 1, 1, 0);
`ifdef STOPWATCH_LAP_EN
        checkOutput("lapReloadValid", 64'(lapValidA), 64'd1);
        checkOutput("lapReloadBcd", 64'(lapA), 64'h000060);
`else
        checkOutput("lapBcdTiedOff", 64'(lapA), 64'h000000);
`endif
        applyStimulus(0, 0, 0, 0, 1, 0);

        tickN(1174);
        checkOutput("time1234", 64'(timeA), 64'h001234);
        resetN      = 1'b0;
        clockDivide = 1'b1;
        applyStimulus(1, 0, 0, 1, 0, 1);
        resetN = 1'b1;
        checkOutput("midRunReset", 64'({runA, ovfA, lapValidA, timeA, lapA}), 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tickN(5);
        checkOutput("ticksIgnoredIdle", 64'(timeA), 64'h000000);

        applyStimulus(1, 0, 0, 0, 0, 0);
        tickN(5999);
        checkOutput("time5999", 64'(timeA), 64'h005999);
        tickN(1);
        checkOutput("minuteCarry", 64'(timeA), 64'h010000);
        checkOutput("noOverflow60", 64'(ovfA), 64'd0);
        checkOutput("wrapLimit1", 64'(timeB), 64'h000000);
        checkOutput("overflowLimit1", 64'(ovfB), 64'd1);
        tickN(3);
        checkOutput("overflowSticky", 64'(ovfB), 64'd1);
        checkOutput("afterWrapLimit1", 64'(timeB), 64'h000003);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("clearOverflow", 64'(ovfB), 64'd0);
        checkOutput("clearTime", 64'(timeA), 64'h000000);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
